// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - packs a serial complex sample stream into NPTS-lane FFT frames
// Optional build macro: FFT_FRAME_LOADER_ZERO_PAD_EN (an early s_last zero-pads the rest of the frame)
module fft_frame_loader #(
    parameter int WIDTH = 16,
    parameter int NPTS  = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_real,
    input  logic [WIDTH-1:0]        s_imag,
    input  logic                    s_last,
    output logic [WIDTH*NPTS-1:0]   fft_data_real,
    output logic [WIDTH*NPTS-1:0]   fft_data_imag,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic                    busy,
    output logic                    frame_err,
    output logic [CNT_W-1:0]        frame_count
);

    localparam int K_W = $clog2(NPTS);
    localparam logic [K_W-1:0] K_LAST = K_W'(NPTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t         state;
    logic [K_W-1:0] k;

    logic accept;
    logic at_last;
    logic frame_end;
    logic len_err;

    assign accept  = s_valid & s_ready;
    assign at_last = (k == K_LAST);

`ifdef FFT_FRAME_LOADER_ZERO_PAD_EN
    logic early_last;
    // An early s_last closes the frame; only a missing s_last on the final lane is an error.
    assign early_last = s_last & ~at_last;
    assign frame_end  = at_last | early_last;
    assign len_err    = ~s_last & at_last;
`else
    // The frame always closes on the NPTS-th accept; s_last is only cross-checked.
    assign frame_end  = at_last;
    assign len_err    = s_last ^ at_last;
`endif

    // Frame sequencer: lane writes, handshake, start pulse, done wait and frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            k             <= '0;
            fft_data_real <= '0;
            fft_data_imag <= '0;
            s_ready       <= 1'b0;
            fft_start     <= 1'b0;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
            frame_count   <= '0;
        end else begin
            fft_start <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_FILL;
                    s_ready <= 1'b1;
                end
                S_FILL: begin
                    if (accept) begin
                        fft_data_real[int'(k)*WIDTH +: WIDTH] <= s_real;
                        fft_data_imag[int'(k)*WIDTH +: WIDTH] <= s_imag;
                        frame_err <= len_err;
`ifdef FFT_FRAME_LOADER_ZERO_PAD_EN
                        if (early_last) begin
                            for (int i = 0; i < NPTS; i++) begin
                                if (i > int'(k)) begin
                                    fft_data_real[i*WIDTH +: WIDTH] <= '0;
                                    fft_data_imag[i*WIDTH +: WIDTH] <= '0;
                                end
                            end
                        end
`endif
                        if (frame_end) begin
                            k         <= '0;
                            state     <= S_FIRE;
                            s_ready   <= 1'b0;
                            fft_start <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fft_done) begin
                        frame_count <= frame_count + CNT_W'(1);
                        state       <= S_FILL;
                        s_ready     <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - scoreboard bench for fft_frame_loader
module tb_fft_frame_loader;

    localparam int WIDTH = 16;
    localparam int NPTS  = 16;
    localparam int CNT_W = 2;
    localparam int LW    = WIDTH * NPTS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [WIDTH-1:0]     s_real = '0;
    logic [WIDTH-1:0]     s_imag = '0;
    logic                 s_last = 1'b0;
    logic [LW-1:0]        fft_data_real;
    logic [LW-1:0]        fft_data_imag;
    logic                 fft_start;
    logic                 fft_done = 1'b0;
    logic                 busy;
    logic                 frame_err;
    logic [CNT_W-1:0]     frame_count;

    fft_frame_loader #(
        .WIDTH(WIDTH),
        .NPTS (NPTS),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_real       (s_real),
        .s_imag       (s_imag),
        .s_last       (s_last),
        .fft_data_real(fft_data_real),
        .fft_data_imag(fft_data_imag),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .busy         (busy),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard queues filled by the driver, drained by the monitor.
    logic [LW-1:0]    exp_re_q[$];
    logic [LW-1:0]    exp_im_q[$];
    int               exp_start_q[$];
    int               exp_err_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    // Reference lane model.
    logic [WIDTH-1:0] m_re[NPTS];
    logic [WIDTH-1:0] m_im[NPTS];
    int               mk = 0;

    // Directed beat table.
    logic [WIDTH-1:0] b_re[NPTS];
    logic [WIDTH-1:0] b_im[NPTS];
    logic             b_last[NPTS];

    task automatic model_clear();
        for (int i = 0; i < NPTS; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        mk = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im,
                                input logic last, output bit done);
        bit err;
        bit pad;
        logic [LW-1:0] vr;
        logic [LW-1:0] vi;
        pad = 1'b0;
`ifdef FFT_FRAME_LOADER_ZERO_PAD_EN
        pad = last && (mk < NPTS - 1);
        err = !last && (mk == NPTS - 1);
`else
        err = (last && (mk < NPTS - 1)) || (!last && (mk == NPTS - 1));
`endif
        m_re[mk] = re;
        m_im[mk] = im;
        if (pad) begin
            for (int i = mk + 1; i < NPTS; i++) begin
                m_re[i] = '0;
                m_im[i] = '0;
            end
        end
        if (err) exp_err_q.push_back(cyc + 1);
        done = pad || (mk == NPTS - 1);
        if (done) begin
            for (int i = 0; i < NPTS; i++) begin
                vr[i*WIDTH +: WIDTH] = m_re[i];
                vi[i*WIDTH +: WIDTH] = m_im[i];
            end
            exp_re_q.push_back(vr);
            exp_im_q.push_back(vi);
            exp_start_q.push_back(cyc + 1);
            mk = 0;
        end else begin
            mk++;
        end
    endtask

    // Presents beats from the table; gap idle cycles after each accept; stops at frame end.
    task automatic send_frame(input int nbeats, input int gap, output int tries0);
        tries0 = 0;
        for (int b = 0; b < nbeats; b++) begin
            bit acc;
            bit done_f;
            int tries;
            acc = 1'b0;
            done_f = 1'b0;
            tries = 0;
            s_valid = 1'b1;
            s_real  = b_re[b];
            s_imag  = b_im[b];
            s_last  = b_last[b];
            while (!acc && tries < 20) begin
                @(negedge clk);
                tries++;
                if (s_ready) begin
                    acc = 1'b1;
                    model_accept(b_re[b], b_im[b], b_last[b], done_f);
                end
                @(posedge clk);
                #1;
            end
            if (b == 0) tries0 = tries;
            if (!acc) begin
                chk("accept_timeout", LW'(acc), LW'(1));
                s_valid = 1'b0;
                return;
            end
            if (done_f) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Holds s_valid high through FIRE/WAIT, then pulses fft_done.
    task automatic wait_done(input logic [CNT_W-1:0] exp_cnt);
        s_valid = 1'b1;
        s_real  = 16'hDEAD;
        s_imag  = 16'hBEEF;
        s_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("wait_s_ready", LW'(s_ready), '0);
            chk("wait_busy", LW'(busy), LW'(1));
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_cnt_q.push_back(exp_cnt);
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        @(negedge clk);
        chk("s_ready_after_done", LW'(s_ready), LW'(1));
        chk("busy_after_done", LW'(busy), '0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: start pulses, error pulses and frame count changes against the scoreboard.
    logic [CNT_W-1:0] prev_fc = '0;
    always @(negedge clk) begin
        if (fft_start) begin
            if (exp_start_q.size() == 0) begin
                chk("unexpected_start", LW'(fft_start), '0);
            end else begin
                chk("start_cycle", LW'(cyc), LW'(exp_start_q.pop_front()));
                chk("lanes_real", fft_data_real, exp_re_q.pop_front());
                chk("lanes_imag", fft_data_imag, exp_im_q.pop_front());
                chk("busy_at_start", LW'(busy), LW'(1));
            end
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) chk("unexpected_frame_err", LW'(frame_err), '0);
            else chk("frame_err_cycle", LW'(cyc), LW'(exp_err_q.pop_front()));
        end
        if (frame_count !== prev_fc) begin
            if (exp_cnt_q.size() == 0) chk("unexpected_count", LW'(frame_count), LW'(prev_fc));
            else chk("frame_count", LW'(frame_count), LW'(exp_cnt_q.pop_front()));
            prev_fc = frame_count;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0;
        model_clear();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", LW'(s_ready), '0);
        chk("rst_fft_start", LW'(fft_start), '0);
        chk("rst_busy", LW'(busy), '0);
        chk("rst_frame_err", LW'(frame_err), '0);
        chk("rst_frame_count", LW'(frame_count), '0);
        chk("rst_lanes_real", fft_data_real, '0);
        chk("rst_lanes_imag", fft_data_imag, '0);

        // Partial frame of 9 beats, then reset mid-frame.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = WIDTH'(i + 1);
            b_im[i] = WIDTH'(100 + i);
            b_last[i] = 1'b0;
        end
        send_frame(9, 0, t0);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_lanes_real", fft_data_real, '0);
        chk("midrst_lanes_imag", fft_data_imag, '0);
        repeat (2) @(posedge clk);
        #1;

        // Impulse frame with s_valid held high across reset release.
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = (i == 0) ? 16'h7FFF : 16'h0000;
            b_im[i] = '0;
            b_last[i] = (i == NPTS - 1);
        end
        s_valid = 1'b1;
        s_real  = b_re[0];
        s_imag  = b_im[0];
        rst_n   = 1'b1;
        @(negedge clk);
        chk("first_cycle_s_ready", LW'(s_ready), '0);
        @(posedge clk);
        #1;
        send_frame(NPTS, 0, t0);
        chk("beat0_tries", LW'(t0), LW'(1));
        // done raised only during FIRE must be ignored
        fft_done = 1'b1;
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        wait_done(2'd1);

        // Ramp frame with s_valid toggling every cycle.
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = WIDTH'(i);
            b_im[i] = WIDTH'(-i);
            b_last[i] = (i == NPTS - 1);
        end
        send_frame(NPTS, 1, t0);
        wait_done(2'd2);

        // Early s_last on beat 7.
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = WIDTH'(16'h1000 + i);
            b_im[i] = WIDTH'(16'h8000 | i);
            b_last[i] = (i == 7) || (i == NPTS - 1);
        end
        send_frame(NPTS, 0, t0);
        wait_done(2'd3);

        // Mixed pattern frame; frame_count wraps to 0.
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = WIDTH'(i * 16'h1111);
            b_im[i] = ~WIDTH'(i * 16'h1111);
            b_last[i] = (i == NPTS - 1);
        end
        send_frame(NPTS, 0, t0);
        wait_done(2'd0);

        // Missing s_last on the final beat.
        for (int i = 0; i < NPTS; i++) begin
            b_re[i] = WIDTH'(16'hF000 - i);
            b_im[i] = WIDTH'(16'h0F00 + 3 * i);
            b_last[i] = 1'b0;
        end
        send_frame(NPTS, 2, t0);
        wait_done(2'd1);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_starts", LW'(exp_start_q.size()), '0);
        chk("pending_errs", LW'(exp_err_q.size()), '0);
        chk("pending_counts", LW'(exp_cnt_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
